cam_window_mux: RTL
===================

CAM_WINDOW_MUX -- requirements
Module: cam_window_mux

Interface
REQ-001 Parameter NUM_CH, default 2: number of camera frame buffers composited.
REQ-002 Parameter IMG_WIDTH, default 160; IMG_HEIGHT, default 120: source frame size.
REQ-003 Parameter SCALE_LOG2, default 1: integer upscale factor of 2^SCALE_LOG2.
REQ-004 Parameter BG_COLOR, default 12'h000: RGB444 value emitted when DE is high and no window hits.
REQ-005 Derived: ADDR_WIDTH = $clog2(IMG_WIDTH*IMG_HEIGHT); CH_W = max(1, $clog2(NUM_CH)).
REQ-006 clk  in  1  pixel clock (25 MHz).
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 x_pixel, y_pixel  in  10 each  raster position from VGA_Syncher.
REQ-009 DE, h_sync, v_sync  in  1 each  raster timing from VGA_Syncher.
REQ-010 cfg_we  in  1  shadow-config write strobe.
REQ-011 cfg_ch  in  CH_W  channel index written.
REQ-012 cfg_en, cfg_mirror  in  1 each  window enable; horizontal mirror.
REQ-013 cfg_x0, cfg_y0  in  10 each  window top-left position on screen.
REQ-014 rd_addr  out  ADDR_WIDTH  shared read address to all frame buffers.
REQ-015 rd_data  in  NUM_CH*16  RGB565 read data; channel i at bits [16i+15:16i]; valid one cycle after rd_addr.
REQ-016 rgb_out  out  12  composited RGB444 pixel.
REQ-017 out_DE, out_h_sync, out_v_sync  out  1 each  timing delayed to match rgb_out.
REQ-018 out_hit  out  1; out_ch  out  CH_W  whether a window hit, and which channel.

Function
REQ-019 Window i hit: active_en[i] and DE and x0<=x<x0+(IMG_WIDTH<<SCALE_LOG2) and y0<=y<y0+(IMG_HEIGHT<<SCALE_LOG2), comparisons at 11 bits so no wrap.
REQ-020 Overlapping hits resolve to the lowest channel index.
REQ-021 Local coordinates: lx=(x-x0)>>SCALE_LOG2, ly=(y-y0)>>SCALE_LOG2; mirrored lx=IMG_WIDTH-1-lx.
REQ-022 rd_addr = ly*IMG_WIDTH + lx of the winning channel, registered at cycle n+1 for inputs sampled at cycle n; held at last value when no hit.
REQ-023 rgb_out registered at cycle n+3: winning channel's RGB565 truncated to {R[15:12],G[10:7],B[4:1]}; BG_COLOR on DE without hit; 12'h000 when DE low.
REQ-024 out_DE/out_h_sync/out_v_sync/out_hit/out_ch = inputs delayed exactly 3 cycles.
REQ-025 cfg_we writes cfg_* into shadow[cfg_ch]; cfg_ch >= NUM_CH is ignored.
REQ-026 Shadow copies to active on the cycle v_sync is sampled 1 then 0 (falling edge); mid-frame writes never change the current frame.
REQ-027 cfg_we coincident with commit: active takes the pre-write shadow; the new write commits at the next frame.
REQ-028 Windows partly off-screen are clipped; no address is produced for off-screen pixels.

Reset
REQ-029 Reset asserted: shadow and active configs cleared (en=0, mirror=0, x0=y0=0), delay pipeline cleared, rd_addr=0, rgb_out=0, all out_* =0.
REQ-030 Reset mid-frame: outputs show 0 from assertion; first commit occurs at the first v_sync falling edge after release.

Configuration
REQ-031 Macro CAM_WINDOW_MUX_MIRROR_EN defined: cfg_mirror stored and applied per REQ-021.
REQ-032 Macro undefined: cfg_mirror port present but ignored, no mirror logic or storage synthesised.

Structure
REQ-033 Package cam_pkg holds rgb565_t, rgb444_t, the RGB565-to-RGB444 function, win_cfg_t struct (en, mirror, x0, y0), and IMG_WIDTH/IMG_HEIGHT defaults.
REQ-034 Sub-module cam_window_hit computes hit and local address for one channel; instantiated NUM_CH times via generate.

Verification
REQ-035 Ch0 en, x0=0, y0=240, SCALE_LOG2=1; x=3,y=245 -> rd_addr=2*160+1=321 at n+1, rgb_out from rd_data ch0 at n+3.
REQ-036 Ch0 and ch1 both at (0,0), both enabled -> out_ch=0 for every hit pixel.
REQ-037 Write ch1 x0=320 mid-frame -> no change in current frame; takes effect after next v_sync falling edge; cfg_we on commit cycle -> effect one frame later.
REQ-038 Mirror on (macro defined), ch0 at (0,0), x=0,y=0 -> rd_addr=159; macro undefined -> rd_addr=0.
REQ-039 DE high, no window -> rgb_out=BG_COLOR; DE low -> 12'h000; out_h_sync equals h_sync delayed 3 cycles.
REQ-040 Assert reset mid-line -> all outputs 0 asynchronously; after release all windows disabled until a commit.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared types and helpers for the camera window compositor.
// RGB565 frame-buffer words are reduced to RGB444 by keeping the top bits of each field.
package cam_pkg;

    localparam int IMG_WIDTH_DEF  = 160;
    localparam int IMG_HEIGHT_DEF = 120;

    typedef logic [15:0] rgb565_t;
    typedef logic [11:0] rgb444_t;

    typedef struct packed {
        logic       en;
        logic       mirror;
        logic [9:0] x0;
        logic [9:0] y0;
    } win_cfg_t;

    function automatic rgb444_t rgb565_to_444(input rgb565_t p);
        return {p[15:12], p[10:7], p[4:1]};
    endfunction

endpackage

// File: rtl/cam_window_hit.sv
// Window hit test and frame-buffer address for one channel.
// Optional feature macro: CAM_WINDOW_MUX_MIRROR_EN (horizontal mirror of the local x).
// Bounds are checked at 11 bits so a window near the right/bottom edge cannot wrap.
module cam_window_hit
    import cam_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
    parameter int SCALE_LOG2 = 1,
    parameter int ADDR_WIDTH = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
    input  win_cfg_t              i_cfg,
    input  logic [9:0]            i_x,
    input  logic [9:0]            i_y,
    input  logic                  i_de,
    output logic                  o_hit,
    output logic [ADDR_WIDTH-1:0] o_addr
);

    localparam logic [10:0] WIN_W = 11'(IMG_WIDTH << SCALE_LOG2);
    localparam logic [10:0] WIN_H = 11'(IMG_HEIGHT << SCALE_LOG2);

    logic [10:0] w_x, w_y, w_x0, w_y0;
    logic [10:0] w_dx, w_dy, w_lx_raw, w_lx, w_ly;

    assign w_x  = {1'b0, i_x};
    assign w_y  = {1'b0, i_y};
    assign w_x0 = {1'b0, i_cfg.x0};
    assign w_y0 = {1'b0, i_cfg.y0};

    // Offsets into the window; only meaningful when the pixel is at or past the origin.
    assign w_dx = w_x - w_x0;
    assign w_dy = w_y - w_y0;

    assign o_hit = i_cfg.en & i_de
                 & (w_x >= w_x0) & (w_dx < WIN_W)
                 & (w_y >= w_y0) & (w_dy < WIN_H);

    assign w_lx_raw = w_dx >> SCALE_LOG2;
    assign w_ly     = w_dy >> SCALE_LOG2;

`ifdef CAM_WINDOW_MUX_MIRROR_EN
    assign w_lx = i_cfg.mirror ? (11'(IMG_WIDTH - 1) - w_lx_raw) : w_lx_raw;
`else
    logic w_unused_mirror;
    assign w_unused_mirror = i_cfg.mirror;
    assign w_lx = w_lx_raw;
`endif

    assign o_addr = ADDR_WIDTH'(w_ly) * ADDR_WIDTH'(IMG_WIDTH) + ADDR_WIDTH'(w_lx);

endmodule

// File: rtl/cam_window_mux.sv
// Composites NUM_CH upscaled camera frame buffers onto the VGA raster.
// Optional feature macro: CAM_WINDOW_MUX_MIRROR_EN (per-window horizontal mirror).
// Latency: rd_addr one clock after the raster inputs, rgb_out and out_* three clocks after.
// Window config is double-buffered and only becomes active on a v_sync falling edge.
module cam_window_mux
    import cam_pkg::*;
#(
    parameter int          NUM_CH     = 2,
    parameter int          IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int          IMG_HEIGHT = IMG_HEIGHT_DEF,
    parameter int          SCALE_LOG2 = 1,
    parameter logic [11:0] BG_COLOR   = 12'h000,
    localparam int         ADDR_WIDTH = $clog2(IMG_WIDTH * IMG_HEIGHT),
    localparam int         CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [9:0]             x_pixel,
    input  logic [9:0]             y_pixel,
    input  logic                   DE,
    input  logic                   h_sync,
    input  logic                   v_sync,
    input  logic                   cfg_we,
    input  logic [CH_W-1:0]        cfg_ch,
    input  logic                   cfg_en,
    input  logic                   cfg_mirror,
    input  logic [9:0]             cfg_x0,
    input  logic [9:0]             cfg_y0,
    output logic [ADDR_WIDTH-1:0]  rd_addr,
    input  logic [NUM_CH*16-1:0]   rd_data,
    output logic [11:0]            rgb_out,
    output logic                   out_DE,
    output logic                   out_h_sync,
    output logic                   out_v_sync,
    output logic                   out_hit,
    output logic [CH_W-1:0]        out_ch
);

    win_cfg_t r_shadow [NUM_CH];
    win_cfg_t r_active [NUM_CH];
    win_cfg_t w_cfg_new;
    logic     r_vs_q;
    logic     w_commit;

    logic [NUM_CH-1:0]     w_hit;
    logic [ADDR_WIDTH-1:0] w_addr [NUM_CH];
    logic                  w_any_hit;
    logic [CH_W-1:0]       w_win_ch;
    logic [ADDR_WIDTH-1:0] w_win_addr;
    logic [ADDR_WIDTH-1:0] r_rd_addr;

    logic [2:0]      r_de_sr, r_hs_sr, r_vs_sr, r_hit_sr;
    logic [CH_W-1:0] r_ch_sr [3];
    rgb565_t         w_pix;
    rgb444_t         w_rgb_next;
    rgb444_t         r_rgb;

    // Assemble the incoming config word; mirror is dropped entirely when the feature is off.
    always_comb begin
        w_cfg_new    = '0;
        w_cfg_new.en = cfg_en;
        w_cfg_new.x0 = cfg_x0;
        w_cfg_new.y0 = cfg_y0;
`ifdef CAM_WINDOW_MUX_MIRROR_EN
        w_cfg_new.mirror = cfg_mirror;
`endif
    end

`ifndef CAM_WINDOW_MUX_MIRROR_EN
    logic w_unused_cfg_mirror;
    assign w_unused_cfg_mirror = cfg_mirror;
`endif

    assign w_commit = r_vs_q & ~v_sync;

    // Shadow/active config: commit reads the shadow before a same-cycle write lands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vs_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            r_vs_q <= v_sync;
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_commit)
                    r_active[i] <= r_shadow[i];
                if (cfg_we && (cfg_ch == CH_W'(i)))
                    r_shadow[i] <= w_cfg_new;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_win
        cam_window_hit #(
            .IMG_WIDTH  (IMG_WIDTH),
            .IMG_HEIGHT (IMG_HEIGHT),
            .SCALE_LOG2 (SCALE_LOG2),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_hit (
            .i_cfg  (r_active[g]),
            .i_x    (x_pixel),
            .i_y    (y_pixel),
            .i_de   (DE),
            .o_hit  (w_hit[g]),
            .o_addr (w_addr[g])
        );
    end

    // Priority select: scanning downward leaves the lowest hitting channel as winner.
    always_comb begin
        w_any_hit  = 1'b0;
        w_win_ch   = '0;
        w_win_addr = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_any_hit  = 1'b1;
                w_win_ch   = CH_W'(i);
                w_win_addr = w_addr[i];
            end
        end
    end

    // Read address holds its last value between hits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_rd_addr <= '0;
        else if (w_any_hit)
            r_rd_addr <= w_win_addr;
    end

    // Timing/hit delay line; stage 1 lines up with the returning read data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_de_sr  <= '0;
            r_hs_sr  <= '0;
            r_vs_sr  <= '0;
            r_hit_sr <= '0;
            for (int i = 0; i < 3; i++)
                r_ch_sr[i] <= '0;
        end else begin
            r_de_sr    <= {r_de_sr[1:0], DE};
            r_hs_sr    <= {r_hs_sr[1:0], h_sync};
            r_vs_sr    <= {r_vs_sr[1:0], v_sync};
            r_hit_sr   <= {r_hit_sr[1:0], w_any_hit};
            r_ch_sr[0] <= w_win_ch;
            r_ch_sr[1] <= r_ch_sr[0];
            r_ch_sr[2] <= r_ch_sr[1];
        end
    end

    // Pick the winning channel's word out of the shared read bus and convert it.
    always_comb begin
        w_pix = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_ch_sr[1] == CH_W'(i))
                w_pix = rd_data[i*16 +: 16];
        end
        if (!r_de_sr[1])
            w_rgb_next = 12'h000;
        else if (r_hit_sr[1])
            w_rgb_next = rgb565_to_444(w_pix);
        else
            w_rgb_next = BG_COLOR;
    end

    // Output pixel register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_rgb <= '0;
        else
            r_rgb <= w_rgb_next;
    end

    assign rd_addr    = r_rd_addr;
    assign rgb_out    = r_rgb;
    assign out_DE     = r_de_sr[2];
    assign out_h_sync = r_hs_sr[2];
    assign out_v_sync = r_vs_sr[2];
    assign out_hit    = r_hit_sr[2];
    assign out_ch     = r_ch_sr[2];

endmodule
